// File: rtl/regfile_wb_writer_if.sv
// Aux (mul/div) result handshake into the register-file writeback merger.
// The source drives valid/addr/data and holds them while out_aux_ready is low.
interface regfile_wb_writer_if;
   logic        in_aux_valid;
   logic [4:0]  in_aux_addr;
   logic [31:0] in_aux_data;
   logic        out_aux_ready;

   modport master (output in_aux_valid, in_aux_addr, in_aux_data, input out_aux_ready);
   modport slave  (input in_aux_valid, in_aux_addr, in_aux_data, output out_aux_ready);
endinterface

// File: rtl/regfile_wb_writer.sv
// Register-file write port merger: pipeline WB wins, aux results queue in a FIFO.
// Optional WB_STATS_EN adds saturating issued-aux-write and squashed-entry counters.
module regfile_wb_writer #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic               in_clk,
   input  logic               in_rst_n,
   regfile_wb_writer_if.slave aux,
   input  logic               in_pipe_wena,
   input  logic [4:0]         in_pipe_addr,
   input  logic [31:0]        in_pipe_data,
   output logic               out_rd_wena,
   output logic [4:0]         out_rd_addr,
   output logic [31:0]        out_rd_data,
   output logic [31:0]        out_pending_mask,
   output logic               out_pipe_stall,
   output logic               out_waw_squash
`ifdef WB_STATS_EN
   ,
   output logic [31:0]        out_aux_wr_cnt,
   output logic [31:0]        out_squash_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_TC = CW'(STARVE_MAX);

   logic [4:0]       ent_addr [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [CW-1:0]    starve_cnt;
   logic             ready_en;

   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             head_live;
   logic             head_issue;
   logic             pipe_issue;
   logic [DEPTH-1:0] squash_hit;

   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
   assign aux.out_aux_ready = ready_en && !full;

   assign push       = aux.in_aux_valid && aux.out_aux_ready && (aux.in_aux_addr != 5'd0);
   assign pipe_issue = in_pipe_wena && (in_pipe_addr != 5'd0);
   assign head_live  = !empty && ent_vld[rd_idx];
   assign head_issue = head_live && !pipe_issue;
   // A squashed head leaves even under a pipe write so it can never clog the queue.
   assign pop        = !empty && (!pipe_issue || !ent_vld[rd_idx]);
   assign out_pipe_stall = (starve_cnt == STARVE_TC);

   always_comb begin
      squash_hit       = '0;
      out_pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) begin
            out_pending_mask[ent_addr[i]] = 1'b1;
            if (pipe_issue && (ent_addr[i] == in_pipe_addr))
               squash_hit[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (push) begin
         ent_addr[wr_idx] <= aux.in_aux_addr;
         ent_data[wr_idx] <= aux.in_aux_data;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         ent_vld        <= '0;
         ready_en       <= 1'b0;
         starve_cnt     <= '0;
         out_waw_squash <= 1'b0;
         out_rd_wena    <= 1'b0;
         out_rd_addr    <= '0;
         out_rd_data    <= '0;
      end else begin
         ready_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         ent_vld <= ent_vld & ~squash_hit;
         if (pop)  ent_vld[rd_idx] <= 1'b0;
         if (push) ent_vld[wr_idx] <= 1'b1;

         if (empty || pop || out_pipe_stall)
            starve_cnt <= '0;
         else if (head_live && pipe_issue)
            starve_cnt <= starve_cnt + 1'b1;

         if (|squash_hit) out_waw_squash <= 1'b1;

         if (pipe_issue) begin
            out_rd_wena <= 1'b1;
            out_rd_addr <= in_pipe_addr;
            out_rd_data <= in_pipe_data;
         end else if (head_issue) begin
            out_rd_wena <= 1'b1;
            out_rd_addr <= ent_addr[rd_idx];
            out_rd_data <= ent_data[rd_idx];
         end else begin
            out_rd_wena <= 1'b0;
            out_rd_addr <= '0;
            out_rd_data <= '0;
         end
      end
   end

`ifdef WB_STATS_EN
   localparam int SW = AW + 1;
   logic [SW-1:0] squash_n;
   logic [32:0]   aux_sum;
   logic [32:0]   sq_sum;

   always_comb begin
      squash_n = '0;
      for (int i = 0; i < DEPTH; i++)
         squash_n = squash_n + SW'(squash_hit[i]);
   end

   assign aux_sum = {1'b0, out_aux_wr_cnt} + 33'(head_issue);
   assign sq_sum  = {1'b0, out_squash_cnt} + 33'(squash_n);

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_aux_wr_cnt <= '0;
         out_squash_cnt <= '0;
      end else begin
         out_aux_wr_cnt <= aux_sum[32] ? 32'hFFFF_FFFF : aux_sum[31:0];
         out_squash_cnt <= sq_sum[32]  ? 32'hFFFF_FFFF : sq_sum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed self-checking bench for regfile_wb_writer (DEPTH=4, STARVE_MAX=8).
module tb_regfile_wb_writer;
   logic        in_clk = 1'b0;
   logic        in_rst_n = 1'b0;
   logic        in_pipe_wena;
   logic [4:0]  in_pipe_addr;
   logic [31:0] in_pipe_data;
   logic        out_rd_wena;
   logic [4:0]  out_rd_addr;
   logic [31:0] out_rd_data;
   logic [31:0] out_pending_mask;
   logic        out_pipe_stall;
   logic        out_waw_squash;
`ifdef WB_STATS_EN
   logic [31:0] out_aux_wr_cnt;
   logic [31:0] out_squash_cnt;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   regfile_wb_writer_if aux_if ();

   always #5 in_clk = ~in_clk;

   regfile_wb_writer #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .in_clk           (in_clk),
      .in_rst_n         (in_rst_n),
      .aux              (aux_if),
      .in_pipe_wena     (in_pipe_wena),
      .in_pipe_addr     (in_pipe_addr),
      .in_pipe_data     (in_pipe_data),
      .out_rd_wena      (out_rd_wena),
      .out_rd_addr      (out_rd_addr),
      .out_rd_data      (out_rd_data),
      .out_pending_mask (out_pending_mask),
      .out_pipe_stall   (out_pipe_stall),
      .out_waw_squash   (out_waw_squash)
`ifdef WB_STATS_EN
      ,
      .out_aux_wr_cnt   (out_aux_wr_cnt),
      .out_squash_cnt   (out_squash_cnt)
`endif
   );

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic idle();
      aux_if.in_aux_valid = 1'b0;
      aux_if.in_aux_addr  = '0;
      aux_if.in_aux_data  = '0;
      in_pipe_wena = 1'b0;
      in_pipe_addr = '0;
      in_pipe_data = '0;
   endtask

   task automatic test_reset();
      idle();
      in_rst_n = 1'b0;
      #12;
      n_tests++;
      if (out_rd_wena !== 1'b0 || out_rd_addr !== 5'd0 || out_rd_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rd: wena=%b addr=%0d data=%h, want 0 0 0", out_rd_wena, out_rd_addr, out_rd_data);
      end
      n_tests++;
      if (out_pending_mask !== 32'd0 || out_pipe_stall !== 1'b0 || out_waw_squash !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: mask=%h stall=%b squash=%b, want 0", out_pending_mask, out_pipe_stall, out_waw_squash);
      end
      n_tests++;
      if (aux_if.out_aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_low: got %b want 0", aux_if.out_aux_ready);
      end
      @(posedge in_clk);
      #1;
      in_rst_n = 1'b1;
      tick();
      n_tests++;
      if (aux_if.out_aux_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_high: got %b want 1", aux_if.out_aux_ready);
      end
   endtask

   task automatic test_starve();
      for (int k = 0; k < 4; k++) begin
         aux_if.in_aux_valid = 1'b1;
         aux_if.in_aux_addr  = 5'(9 + k);
         aux_if.in_aux_data  = 32'h900 + k;
         in_pipe_wena = 1'b1;
         in_pipe_addr = 5'd3;
         in_pipe_data = 32'h3000 + k;
         tick();
      end
      aux_if.in_aux_valid = 1'b0;
      n_tests++;
      if (aux_if.out_aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_full_ready: got %b want 0", aux_if.out_aux_ready);
      end
      n_tests++;
      if (out_pending_mask !== 32'h0000_1E00) begin
         n_fail++;
         $display("FAIL starve_mask_full: got %h want 00001e00", out_pending_mask);
      end
      n_tests++;
      if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'd3 || out_rd_data !== 32'h3003) begin
         n_fail++;
         $display("FAIL starve_pipe_wins: wena=%b addr=%0d data=%h want 1 3 3003", out_rd_wena, out_rd_addr, out_rd_data);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (out_pipe_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_early_stall: cycle %0d got %b want 0", k, out_pipe_stall);
         end
      end
      tick();
      n_tests++;
      if (out_pipe_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_stall_pulse: got %b want 1", out_pipe_stall);
      end
      tick();
      n_tests++;
      if (out_pipe_stall !== 1'b0 || out_rd_addr !== 5'd3 || aux_if.out_aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_stall_one_cycle: stall=%b addr=%0d ready=%b want 0 3 0", out_pipe_stall, out_rd_addr, aux_if.out_aux_ready);
      end
      in_pipe_wena = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'(9 + k) || out_rd_data !== 32'h900 + k) begin
            n_fail++;
            $display("FAIL starve_order: k=%0d wena=%b addr=%0d data=%h want 1 %0d %h", k, out_rd_wena, out_rd_addr, out_rd_data, 9 + k, 32'h900 + k);
         end
         if (k == 0) begin
            n_tests++;
            if (aux_if.out_aux_ready !== 1'b1 || out_pending_mask !== 32'h0000_1C00) begin
               n_fail++;
               $display("FAIL starve_first_pop: ready=%b mask=%h want 1 00001c00", aux_if.out_aux_ready, out_pending_mask);
            end
         end
      end
      n_tests++;
      if (out_pending_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL starve_mask_drained: got %h want 0", out_pending_mask);
      end
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_idle_after: wena=%b want 0", out_rd_wena);
      end
`ifdef WB_STATS_EN
      n_tests++;
      if (out_aux_wr_cnt !== 32'd4 || out_squash_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stats_after_starve: wr=%0d sq=%0d want 4 0", out_aux_wr_cnt, out_squash_cnt);
      end
`endif
   endtask

   task automatic test_waw();
      n_tests++;
      if (out_waw_squash !== 1'b0) begin
         n_fail++;
         $display("FAIL waw_flag_initial: got %b want 0", out_waw_squash);
      end
      aux_if.in_aux_valid = 1'b1;
      aux_if.in_aux_addr  = 5'd7;
      aux_if.in_aux_data  = 32'h0000_AAAA;
      tick();
      aux_if.in_aux_valid = 1'b0;
      n_tests++;
      if (out_pending_mask !== 32'h0000_0080 || out_rd_wena !== 1'b0) begin
         n_fail++;
         $display("FAIL waw_queued: mask=%h wena=%b want 00000080 0", out_pending_mask, out_rd_wena);
      end
      in_pipe_wena = 1'b1;
      in_pipe_addr = 5'd7;
      in_pipe_data = 32'h0000_BBBB;
      tick();
      in_pipe_wena = 1'b0;
      n_tests++;
      if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'd7 || out_rd_data !== 32'h0000_BBBB) begin
         n_fail++;
         $display("FAIL waw_pipe_write: wena=%b addr=%0d data=%h want 1 7 0000bbbb", out_rd_wena, out_rd_addr, out_rd_data);
      end
      n_tests++;
      if (out_pending_mask !== 32'd0 || out_waw_squash !== 1'b1) begin
         n_fail++;
         $display("FAIL waw_squash: mask=%h flag=%b want 0 1", out_pending_mask, out_waw_squash);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         n_tests++;
         if (out_rd_wena !== 1'b0 || aux_if.out_aux_ready !== 1'b1 || out_waw_squash !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_silent_pop: k=%0d wena=%b data=%h ready=%b flag=%b want 0 - 1 1", k, out_rd_wena, out_rd_data, aux_if.out_aux_ready, out_waw_squash);
         end
      end
`ifdef WB_STATS_EN
      n_tests++;
      if (out_aux_wr_cnt !== 32'd4 || out_squash_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL stats_after_waw: wr=%0d sq=%0d want 4 1", out_aux_wr_cnt, out_squash_cnt);
      end
`endif
   endtask

   task automatic test_single();
      n_tests++;
      if (out_pending_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL single_mask_before: got %h want 0", out_pending_mask);
      end
      aux_if.in_aux_valid = 1'b1;
      aux_if.in_aux_addr  = 5'd8;
      aux_if.in_aux_data  = 32'h1234_5678;
      tick();
      aux_if.in_aux_valid = 1'b0;
      n_tests++;
      if (out_pending_mask !== 32'h0000_0100 || out_rd_wena !== 1'b0) begin
         n_fail++;
         $display("FAIL single_queued: mask=%h wena=%b want 00000100 0", out_pending_mask, out_rd_wena);
      end
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'd8 || out_rd_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL single_issue: wena=%b addr=%0d data=%h want 1 8 12345678", out_rd_wena, out_rd_addr, out_rd_data);
      end
      n_tests++;
      if (out_pending_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL single_mask_clear: got %h want 0", out_pending_mask);
      end
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b0) begin
         n_fail++;
         $display("FAIL single_once: wena=%b want 0", out_rd_wena);
      end
   endtask

   task automatic test_addr0();
      aux_if.in_aux_valid = 1'b1;
      aux_if.in_aux_addr  = 5'd0;
      aux_if.in_aux_data  = 32'hDEAD_BEEF;
      in_pipe_wena = 1'b1;
      in_pipe_addr = 5'd0;
      in_pipe_data = 32'hCAFE_0000;
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b0 || out_pending_mask !== 32'd0 || aux_if.out_aux_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL addr0_dropped: wena=%b mask=%h ready=%b want 0 0 1", out_rd_wena, out_pending_mask, aux_if.out_aux_ready);
      end
      aux_if.in_aux_addr = 5'd5;
      aux_if.in_aux_data = 32'h0000_0055;
      tick();
      aux_if.in_aux_valid = 1'b0;
      n_tests++;
      if (out_rd_wena !== 1'b0 || out_pending_mask !== 32'h0000_0020) begin
         n_fail++;
         $display("FAIL addr0_enqueue5: wena=%b mask=%h want 0 00000020", out_rd_wena, out_pending_mask);
      end
      tick();
      in_pipe_wena = 1'b0;
      n_tests++;
      if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'd5 || out_rd_data !== 32'h0000_0055) begin
         n_fail++;
         $display("FAIL addr0_no_block: wena=%b addr=%0d data=%h want 1 5 00000055", out_rd_wena, out_rd_addr, out_rd_data);
      end
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b0 || out_pending_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL addr0_idle: wena=%b mask=%h want 0 0", out_rd_wena, out_pending_mask);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         aux_if.in_aux_valid = 1'b1;
         aux_if.in_aux_addr  = 5'(20 + k);
         aux_if.in_aux_data  = 32'h2000 + k;
         in_pipe_wena = 1'b1;
         in_pipe_addr = 5'd3;
         in_pipe_data = 32'h0303;
         tick();
      end
      n_tests++;
      if (out_pending_mask !== 32'h0070_0000) begin
         n_fail++;
         $display("FAIL rstmid_queued: mask=%h want 00700000", out_pending_mask);
      end
      #2;
      in_rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_rd_wena !== 1'b0 || out_rd_addr !== 5'd0 || out_rd_data !== 32'd0 || out_pending_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL rstmid_async: wena=%b addr=%0d data=%h mask=%h want all 0", out_rd_wena, out_rd_addr, out_rd_data, out_pending_mask);
      end
      n_tests++;
      if (out_pipe_stall !== 1'b0 || out_waw_squash !== 1'b0 || aux_if.out_aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_flags: stall=%b squash=%b ready=%b want 0 0 0", out_pipe_stall, out_waw_squash, aux_if.out_aux_ready);
      end
      idle();
      @(posedge in_clk);
      #1;
      in_rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_tests++;
         if (out_rd_wena !== 1'b0 || out_pending_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_stale: k=%0d wena=%b addr=%0d mask=%h want 0 - 0", k, out_rd_wena, out_rd_addr, out_pending_mask);
         end
      end
      aux_if.in_aux_valid = 1'b1;
      aux_if.in_aux_addr  = 5'd1;
      aux_if.in_aux_data  = 32'h0000_0011;
      tick();
      aux_if.in_aux_valid = 1'b0;
      tick();
      n_tests++;
      if (out_rd_wena !== 1'b1 || out_rd_addr !== 5'd1 || out_rd_data !== 32'h0000_0011) begin
         n_fail++;
         $display("FAIL rstmid_recover: wena=%b addr=%0d data=%h want 1 1 00000011", out_rd_wena, out_rd_addr, out_rd_data);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      test_reset();
      test_starve();
      test_waw();
      test_single();
      test_addr0();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_writer.md
Name: regfile_wb_writer

Overview:
- Write-side initiator for the CPU register file.
- Merges two writeback sources and produces the single register-file write port (wena/addr/data), registered.
- The in-order pipeline WB result takes priority. Results from the multi-cycle unit (mul/div) arrive by valid/ready handshake and queue in a small FIFO.
- Publishes a pending-write mask that the hazard unit uses to stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, aux FIFO entries (power of two, 2..16).
- STARVE_MAX, 8, cycles a FIFO head may wait before the block requests a pipeline stall.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_pipe_wena  input  1  pipeline WB write valid; no backpressure, must be consumed the same cycle.
- in_pipe_addr  input  5  pipeline WB destination register.
- in_pipe_data  input  32  pipeline WB data.
- in_aux_valid  input  1  multi-cycle unit result valid.
- in_aux_addr  input  5  multi-cycle result destination.
- in_aux_data  input  32  multi-cycle result data.
- out_aux_ready  output  1  FIFO can accept; equals !full.
- out_rd_wena  output  1  register-file write enable.
- out_rd_addr  output  5  register-file write address.
- out_rd_data  output  32  register-file write data.
- out_pending_mask  output  32  bit r set while a live FIFO entry targets register r; bit 0 always 0.
- out_pipe_stall  output  1  request to hold the pipeline WB for one cycle.
- out_waw_squash  output  1  sticky flag: an aux entry was squashed by a younger pipeline write.

Behaviour:
- Reset (async, in_rst_n=0), all outputs 0:
  - out_rd_wena/addr/data, out_pipe_stall, out_waw_squash all 0.
  - FIFO empty; all entry valid bits cleared; out_pending_mask=0; starve counter 0.
  - out_aux_ready=1 once reset is released.
  - Reset mid-operation discards all queued entries with no write issued.
- Aux accept:
  - Handshake completes when in_aux_valid && out_aux_ready.
  - addr 0: accepted and dropped, never enqueued.
  - Otherwise enqueued at the tail with entry-valid=1.
  - If full, ready=0 and the source holds its inputs stable.
- Issue arbitration, evaluated each cycle, with the result registered to the out_rd_* outputs (1-cycle latency):
  - Pipe write (in_pipe_wena && addr!=0) drives the port.
  - Otherwise the FIFO head is popped and drives the port, if its entry is live.
  - A squashed head is popped silently: out_rd_wena=0, no port use, so it costs one cycle.
  - Otherwise out_rd_wena=0.
  - Pipe writes to addr 0 are ignored and do not block aux issue.
- WAW squash:
  - When a pipe write to register r is issued, every live FIFO entry with addr r is marked invalid (stale older value).
  - out_waw_squash is set and held until reset.
  - The entry still occupies its slot until popped.
- Pending mask:
  - Combinational OR over live entries, decoded by address.
  - Updates the cycle after enqueue or squash.
  - Bit clears in the cycle the entry is popped (the write lands on the out_rd_* outputs that cycle).
- Starvation:
  - Counter increments each cycle a live head is blocked by a pipe write; it clears when the head pops or the FIFO is empty.
  - When counter==STARVE_MAX, out_pipe_stall=1 for exactly one cycle and the counter clears.
  - The pipeline must present in_pipe_wena=0 in the following cycle; the head issues then.
- Simultaneous push and pop on a full FIFO:
  - ready reflects the pre-pop full state, so no push occurs.
  - Push and pop on a non-full FIFO both proceed.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra wrap bit.

Optional Feature:
- Macro WB_STATS_EN.
- When defined, adds out_aux_wr_cnt (32), counting aux writes actually issued, and out_squash_cnt (32), counting squashed entries. Both reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, both ports and counters are absent and there is no other behavioural change.

Test Plan:
- Reset, then aux push {addr 8, 0x12345678} with the pipe idle -> next cycle out_rd_wena=1, addr=8, data=0x12345678; pending_mask bit8 high for exactly the cycle between enqueue and pop.
- Push DEPTH=4 aux entries (addr 9..12) while the pipe writes addr 3 every cycle -> out_aux_ready=0 after 4th push. out_pipe_stall pulses once STARVE_MAX=8 blocked cycles have elapsed. Pipe held idle next cycle -> addr 9 issues; order 9,10,11,12 preserved.
- Aux push addr 7=0xAAAA, then pipe write addr 7=0xBBBB before the head issues -> port writes only 0xBBBB to r7; out_waw_squash=1; pending bit7 clears; one idle pop cycle.
- Aux push addr 0 and pipe write addr 0 -> accepted, no FIFO entry, out_rd_wena stays 0, aux issue unaffected.
- Assert in_rst_n=0 asynchronously with 3 entries queued mid-cycle -> all outputs 0 immediately. After release, no stale writes ever appear on the port.
- With WB_STATS_EN: run scenarios 2 and 3 -> out_aux_wr_cnt=4 after scenario 2 and remains 4 after scenario 3 (squashed entry not counted); out_squash_cnt=1.
